bcd_seq_subtractor: RTL and testbench

BCD_SEQ_SUBTRACTOR -- requirements
Module: bcd_seq_subtractor

---
 rtl/bcd_seq_subtractor.sv | 176 +++++++++++++++++
 tb/tb_bcd_seq_subtractor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_subtractor.sv
// Sequential BCD subtractor: computes A - B - Bin one digit per clock,
// LSD first, then converts a ten's-complement result into a magnitude
// with a second digit-serial pass when the final borrow is set.
module bcd_seq_subtractor #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  input  logic              Bin,
  output logic              Busy,
  output logic              Done,
  output logic [4*NDIG-1:0] Diff,
  output logic              Bout,
  output logic              Neg,
  output logic              Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, state_n;
  logic [4*NDIG-1:0] a_r, b_r, raw_r;
  logic [4*NDIG-1:0] raw_upd_s;
  logic [3:0]        cnt_r;
  logic              br_r, err_r;
  logic              busy_r, done_r;
  logic [3:0]        x_dig_s, y_dig_s, a_dig_s, b_dig_s, d_dig_s;
  logic              d_br_s, dig_err_s;
  logic [4:0]        sub_s;

  // One BCD digit of x - y - bi; returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_digit_sub(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       bi);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'd0, bi};
    if (t[4]) begin
      bcd_digit_sub = {1'b1, 4'(t + 5'd10)};
    end else begin
      bcd_digit_sub = {1'b0, t[3:0]};
    end
  endfunction

  // Select the current digit pair and compute the digit result and write-back image.
  always_comb begin
    a_dig_s   = 4'd0;
    b_dig_s   = 4'd0;
    y_dig_s   = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      a_dig_s = (cnt_r == 4'(i)) ? a_r[4*i +: 4]   : a_dig_s;
      b_dig_s = (cnt_r == 4'(i)) ? b_r[4*i +: 4]   : b_dig_s;
      y_dig_s = (cnt_r == 4'(i)) ? raw_r[4*i +: 4] : y_dig_s;
    end
    // COMP pass computes 0 - raw; CALC pass computes a - b.
    if (state_r == COMP) begin
      x_dig_s = 4'd0;
    end else begin
      x_dig_s = a_dig_s;
      y_dig_s = b_dig_s;
    end
    dig_err_s = (a_dig_s > 4'd9) || (b_dig_s > 4'd9);
    sub_s     = bcd_digit_sub(x_dig_s, y_dig_s, br_r);
    d_br_s    = sub_s[4];
    d_dig_s   = sub_s[3:0];
    raw_upd_s = raw_r;
    for (int i = 0; i < NDIG; i++) begin
      raw_upd_s[4*i +: 4] = (cnt_r == 4'(i)) ? d_dig_s : raw_r[4*i +: 4];
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (Start) state_n = CALC;
        else       state_n = IDLE;
      end
      CALC: begin
        // Last CALC cycle is a decision cycle after all digits are done.
        if (cnt_r == 4'(NDIG)) begin
          if (br_r && !err_r) state_n = COMP;
          else                state_n = DONE;
        end else begin
          state_n = CALC;
        end
      end
      COMP: begin
        if (cnt_r == 4'(NDIG - 1)) state_n = DONE;
        else                        state_n = COMP;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      raw_r   <= '0;
      cnt_r   <= 4'd0;
      br_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
      Neg     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == CALC) || (state_n == COMP);
      done_r  <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (Start) begin
            a_r   <= A;
            b_r   <= B;
            br_r  <= Bin;
            raw_r <= '0;
            cnt_r <= 4'd0;
            err_r <= 1'b0;
          end
        end
        CALC: begin
          if (cnt_r == 4'(NDIG)) begin
            cnt_r <= 4'd0;
            br_r  <= 1'b0;
            if (!(br_r && !err_r)) begin
              Diff <= err_r ? '0 : raw_r;
              Bout <= err_r ? 1'b0 : br_r;
              Neg  <= err_r ? 1'b0 : br_r;
              Err  <= err_r;
            end
          end else begin
            raw_r <= raw_upd_s;
            br_r  <= d_br_s;
            err_r <= err_r | dig_err_s;
            cnt_r <= cnt_r + 4'd1;
          end
        end
        COMP: begin
          raw_r <= raw_upd_s;
          br_r  <= d_br_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'(NDIG - 1)) begin
            Diff <= raw_upd_s;
            Bout <= 1'b1;
            Neg  <= 1'b1;
            Err  <= 1'b0;
          end
        end
        DONE: begin
          cnt_r <= 4'd0;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;

endmodule

// File: tb/tb_bcd_seq_subtractor.sv
// Self-checking bench for bcd_seq_subtractor (NDIG=4) with an
// integer-arithmetic reference model and a result scoreboard.
module tb_bcd_seq_subtractor;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Bin   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Busy, Done, Bout, Neg, Err;
  logic [W-1:0] Diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         neg;
    logic         err;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;

  bcd_seq_subtractor #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout), .Neg(Neg), .Err(Err)
  );

  always #5 clk = ~clk;

  // Reference: decimal arithmetic on integers, independent of digit-serial hardware.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    exp_t r;
    int av = 0, bv = 0, pw = 1, v, mag;
    logic e = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
      av += int'(a[4*i +: 4]) * pw;
      bv += int'(b[4*i +: 4]) * pw;
      pw *= 10;
    end
    v = av - bv - int'(bin);
    r.diff = '0;
    r.err  = e;
    if (e) begin
      r.bout = 1'b0;
      r.neg  = 1'b0;
      r.lat  = NDIG + 1;
    end else begin
      r.neg  = (v < 0);
      r.bout = r.neg;
      mag    = (v < 0) ? -v : v;
      mag    = mag % pw;
      for (int i = 0; i < NDIG; i++) begin
        r.diff[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
      r.lat = r.neg ? 2 * NDIG + 1 : NDIG + 1;
    end
    return r;
  endfunction

  // Scoreboard: every Done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && Done === 1'b1) begin
      done_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got Done=1 required no pulse");
      end else begin
        mon_e = exp_q.pop_front();
        if ({Diff, Bout, Neg, Err} !== {mon_e.diff, mon_e.bout, mon_e.neg, mon_e.err}) begin
          failures++;
          $display("FAIL result: got diff=%h bout=%b neg=%b err=%b required diff=%h bout=%b neg=%b err=%b",
                   Diff, Bout, Neg, Err, mon_e.diff, mon_e.bout, mon_e.neg, mon_e.err);
        end
      end
    end
  end

  // Drive one operation, push its expectation, return edges-to-Done and Busy after first edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output int lat, output int exp_lat, output logic busy1);
    exp_t e;
    e = model(a, b, bin);
    exp_lat = e.lat;
    exp_q.push_back(e);
    @(negedge clk);
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    lat = 0;
    busy1 = 1'b0;
    while (Done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = Busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b1; A = 16'h0042; B = 16'h0017;
    repeat (3) @(negedge clk);
    checks++;
    if ({Busy, Done, Bout, Neg, Err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000", {Busy, Done, Bout, Neg, Err});
    end
    checks++;
    if (Diff !== 16'h0000) begin
      failures++;
      $display("FAIL reset_diff: got %h required 0000", Diff);
    end
    Start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b required 0", Busy);
    end
  endtask

  task automatic test_basic();
    int lat, el;
    logic b1;
    issue(16'h0042, 16'h0017, 1'b0, lat, el, b1);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL basic_pos_latency: got %0d required 5", lat);
    end
    checks++;
    if (b1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b required 1", b1);
    end
    @(negedge clk);
    checks++;
    if ({Done, Busy} !== 2'b00) begin
      failures++;
      $display("FAIL done_one_cycle: got done,busy=%b required 00", {Done, Busy});
    end
    issue(16'h0017, 16'h0042, 1'b0, lat, el, b1);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL basic_neg_latency: got %0d required 9", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int lat, el;
    logic b1;
    issue(16'h0000, 16'h0000, 1'b1, lat, el, b1);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL minus_one_latency: got %0d required 9", lat);
    end
    @(negedge clk);
    issue(16'h0000, 16'h9999, 1'b1, lat, el, b1);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL minus_full_latency: got %0d required 9", lat);
    end
    @(negedge clk);
    issue(16'h5678, 16'h5678, 1'b0, lat, el, b1);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL equal_latency: got %0d required 5", lat);
    end
    @(negedge clk);
    issue(16'h9999, 16'h0000, 1'b0, lat, el, b1);
    @(negedge clk);
  endtask

  task automatic test_error();
    int lat, el;
    logic b1;
    issue(16'h00A0, 16'h0001, 1'b0, lat, el, b1);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL err_latency: got %0d required 5", lat);
    end
    @(negedge clk);
    issue(16'h0001, 16'h00F0, 1'b1, lat, el, b1);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL err_borrow_latency: got %0d required 5", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    int lat, el;
    logic b1;
    e = model(16'h0100, 16'h0001, 1'b0);
    issue(16'h0100, 16'h0001, 1'b0, lat, el, b1);
    A = 16'h3333; B = 16'h1111; Bin = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({Diff, Bout, Neg, Err} !== {e.diff, e.bout, e.neg, e.err}) begin
      failures++;
      $display("FAIL hold: got %h/%b%b%b required %h/%b%b%b",
               Diff, Bout, Neg, Err, e.diff, e.bout, e.neg, e.err);
    end
  endtask

  task automatic test_start_ignored();
    int lat, d0;
    exp_q.push_back(model(16'h0017, 16'h0042, 1'b0));
    d0 = done_count;
    @(negedge clk);
    A = 16'h0017; B = 16'h0042; Bin = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 16'h0900; B = 16'h0100; Bin = 1'b1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    lat = 3;
    while (Done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL ignored_start_latency: got %0d required 9", lat);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (done_count - d0 !== 1) begin
      failures++;
      $display("FAIL ignored_start_pulses: got %0d required 1", done_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    int lat, el, d0;
    logic b1;
    exp_q.push_back(model(16'h0017, 16'h0042, 1'b0));
    @(negedge clk);
    A = 16'h0017; B = 16'h0042; Bin = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    d0 = done_count;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({Busy, Done, Bout, Neg, Err} !== 5'b00000 || Diff !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_outputs: got flags=%b diff=%h required 00000/0000",
               {Busy, Done, Bout, Neg, Err}, Diff);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_count !== d0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", done_count - d0);
    end
    issue(16'h1234, 16'h1234, 1'b0, lat, el, b1);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL after_reset_latency: got %0d required 5", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int lat, el;
    logic b1;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NDIG; i++) begin
        a[4*i +: 4] = 4'($urandom_range(9, 0));
        b[4*i +: 4] = 4'($urandom_range(9, 0));
      end
      issue(a, b, 1'($urandom_range(1, 0)), lat, el, b1);
      checks++;
      if (lat !== el) begin
        failures++;
        $display("FAIL random_latency: got %0d required %0d", lat, el);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_error();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
